core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/r32i_pkg.sv | 63 ++++++
 rtl/pc_reg.sv | 28 ++
 rtl/core_sequencer.sv | 115 +++++++++++
 tb/tb_core_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r32i_pkg.sv
// rtl/r32i_pkg.sv - RV32I opcode constants, sequencer/decoder enums and class decode
package r32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_JUMP, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_FENCE, CLS_SYSTEM
    } insn_class_e;

    typedef struct packed {
        logic        legal;
        insn_class_e cls;
    } decode_t;

    function automatic decode_t decode_insn(input logic [6:0] opcode, input logic [2:0] funct3);
        decode_t d;
        d.legal = 1'b1;
        d.cls   = CLS_ALU;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: d.cls = CLS_ALU;
            OPC_JAL:      d.cls = CLS_JUMP;
            OPC_JALR: begin
                d.cls   = CLS_JUMP;
                d.legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                d.cls   = CLS_BRANCH;
                d.legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                d.cls   = CLS_LOAD;
                d.legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                d.cls   = CLS_STORE;
                d.legal = (funct3 <= 3'b010);
            end
            OPC_MISC_MEM: d.cls = CLS_FENCE;
            OPC_SYSTEM:   d.cls = CLS_SYSTEM;
            default:      d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with target load and modulo +4 increment
module pc_reg #(
    parameter int               dataW    = 32,
    parameter logic [dataW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [dataW-1:0] i_target,
    output logic [dataW-1:0] o_pc
);

    logic [dataW-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + dataW'(4);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control sequencer (fetch/decode/execute/mem/wb)
module core_sequencer
    import r32i_pkg::*;
#(
    parameter int               dataW    = 32,
    parameter logic [dataW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic [dataW-1:0] target_addr,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [dataW-1:0] pc,
    output logic             halted,
    output logic             illegal
);

    state_e      r_state;
    insn_class_e r_cls;
    logic        r_illegal;

    decode_t     w_dec;
    logic        w_misalign;
    logic        w_pc_load;
    logic        w_pc_inc;

    assign w_dec      = decode_insn(opcode, funct3);
    assign w_misalign = (target_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_cls     <= CLS_ALU;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_cls <= w_dec.cls;
                    if (!w_dec.legal) begin
                        r_state   <= ST_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (r_cls)
                        CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
                        CLS_ALU:             r_state <= ST_WB;
                        CLS_FENCE:           r_state <= ST_FETCH;
                        CLS_SYSTEM:          r_state <= ST_HALT;
                        // misaligned control transfers stop the core before pc moves
                        CLS_JUMP: begin
                            r_state   <= w_misalign ? ST_HALT : ST_WB;
                            r_illegal <= w_misalign;
                        end
                        CLS_BRANCH: begin
                            r_state   <= (branch_taken && w_misalign) ? ST_HALT : ST_FETCH;
                            r_illegal <= branch_taken && w_misalign;
                        end
                        default:             r_state <= ST_HALT;
                    endcase
                end
                ST_MEM: if (mem_ready) r_state <= (r_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign w_pc_load = ((r_state == ST_EXECUTE) && (r_cls == CLS_BRANCH) && branch_taken && !w_misalign)
                    || ((r_state == ST_WB) && (r_cls == CLS_JUMP));
    assign w_pc_inc  = ((r_state == ST_EXECUTE) && (((r_cls == CLS_BRANCH) && !branch_taken) || (r_cls == CLS_FENCE)))
                    || ((r_state == ST_MEM) && mem_ready && (r_cls == CLS_STORE))
                    || ((r_state == ST_WB) && (r_cls != CLS_JUMP));

    pc_reg #(
        .dataW    (dataW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_pc_load),
        .i_inc    (w_pc_inc),
        .i_target (target_addr),
        .o_pc     (pc)
    );

    // rst_n gates the request strobes so they fall the instant reset asserts
    assign mem_req      = rst_n && ((r_state == ST_FETCH) || (r_state == ST_MEM));
    assign mem_is_fetch = (r_state != ST_MEM);
    assign mem_we       = (r_state == ST_MEM) && (r_cls == CLS_STORE);
    assign ir_we        = rst_n && (r_state == ST_FETCH) && mem_ready;
    assign reg_we       = (r_state == ST_WB);
    assign halted       = (r_state == ST_HALT);
    assign illegal      = r_illegal;

    always_comb begin
        wb_sel = WB_ALU;
        if (r_state == ST_WB) begin
            if (r_cls == CLS_LOAD)      wb_sel = WB_MEM;
            else if (r_cls == CLS_JUMP) wb_sel = WB_PC4;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - table-driven and randomized bench for core_sequencer
module tb_core_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic [31:0] target_addr;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        ir_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    core_sequencer #(.dataW(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_fetch (mem_is_fetch),
        .ir_we        (ir_we),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          nwe;
        int          wbs;
        bit          halt;
        bit          ill;
        logic [31:0] pc;
        int          nmem;
        int          nmemwe;
    } exp_t;

    typedef struct {
        bit          rst;
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          tk;
        logic [31:0] tgt;
        int          fw;
        int          mw;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Expected behaviour of one instruction, derived from the ISA-level rules.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input bit tk,
                                   input logic [31:0] tgt, input int fw, input int mw,
                                   input logic [31:0] cur);
        exp_t e;
        int   f;
        f = fw + 1;
        e = '{cyc: f + 1, nwe: 0, wbs: 0, halt: 1'b1, ill: 1'b1, pc: cur, nmem: 0, nmemwe: 0};
        case (opc)
            7'h37, 7'h17, 7'h13, 7'h33: e = '{f + 3, 1, 0, 1'b0, 1'b0, cur + 32'd4, 0, 0};
            7'h6F, 7'h67: begin
                if (opc == 7'h67 && f3 != 3'd0) e.cyc = f + 1;
                else if (tgt[1:0] != 2'b00)    e.cyc = f + 2;
                else e = '{f + 3, 1, 2, 1'b0, 1'b0, tgt, 0, 0};
            end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.cyc = f + 1;
                else if (tk && tgt[1:0] != 2'b00) e.cyc = f + 2;
                else e = '{f + 2, 0, 0, 1'b0, 1'b0, tk ? tgt : cur + 32'd4, 0, 0};
            end
            7'h03: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)
                       e = '{f + 2 + mw + 2, 1, 1, 1'b0, 1'b0, cur + 32'd4, mw + 1, 0};
            7'h23: if (f3 < 3'd3)
                       e = '{f + 2 + mw + 1, 0, 0, 1'b0, 1'b0, cur + 32'd4, mw + 1, mw + 1};
            7'h0F: e = '{f + 2, 0, 0, 1'b0, 1'b0, cur + 32'd4, 0, 0};
            7'h73: begin e.cyc = f + 2; e.ill = 1'b0; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset_strobes", 0, 32'({mem_req, ir_we, mem_we, reg_we, wb_sel, mem_is_fetch, halted, illegal}),
            32'b0_0_0_0_00_1_0_0);
        chk("reset_pc", 0, pc, RST_PC);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("post_reset_fetch", 0, 32'({mem_req, mem_is_fetch}), 32'b11);
    endtask

    task automatic exec(input logic [6:0] opc, input logic [2:0] f3, input bit tk, input logic [31:0] tgt,
                        input int fw, input int mw, output exp_t o, output bit ok);
        int fwc;
        int mwc;
        bit left;
        o    = '{0, 0, 0, 1'b0, 1'b0, 32'h0, 0, 0};
        ok   = 1'b0;
        left = 1'b0;
        fwc  = fw;
        mwc  = mw;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            opcode = opc; funct3 = f3; branch_taken = tk; target_addr = tgt;
            if (mem_req && mem_is_fetch) begin
                mem_ready = (fwc == 0);
                if (fwc > 0) fwc--;
            end else if (mem_req) begin
                mem_ready = (mwc == 0);
                if (mwc > 0) mwc--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (ir_we) left = 1'b1;
            if (reg_we) begin o.nwe++; o.wbs = int'(wb_sel); end
            if (mem_req && !mem_is_fetch) begin
                o.nmem++;
                if (mem_we) o.nmemwe++;
            end
            @(posedge clk);
            o.cyc++;
            #1;
            if (halted || (left && mem_req && mem_is_fetch)) begin ok = 1'b1; break; end
        end
        o.halt = halted;
        o.ill  = illegal;
        o.pc   = pc;
    endtask

    task automatic run_check(input string tag, input int idx, input logic [6:0] opc, input logic [2:0] f3,
                             input bit tk, input logic [31:0] tgt, input int fw, input int mw, input exp_t e);
        exp_t o;
        bit   ok;
        exec(opc, f3, tk, tgt, fw, mw, o, ok);
        chk({tag, "_done"},   idx, 32'(ok), 32'd1);
        chk({tag, "_cycles"}, idx, o.cyc, e.cyc);
        chk({tag, "_regwe"},  idx, o.nwe, e.nwe);
        if (e.nwe > 0) chk({tag, "_wbsel"}, idx, o.wbs, e.wbs);
        chk({tag, "_halt"},   idx, 32'(o.halt), 32'(e.halt));
        chk({tag, "_illegal"},idx, 32'(o.ill), 32'(e.ill));
        chk({tag, "_pc"},     idx, o.pc, e.pc);
        chk({tag, "_memreq"}, idx, o.nmem, e.nmem);
        chk({tag, "_memwe"},  idx, o.nmemwe, e.nmemwe);
        if (e.halt) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                mem_ready = 1'b1;
                #1;
                chk({tag, "_halt_sticky"}, idx, 32'({halted, mem_req, mem_we, ir_we, reg_we}), 32'b10000);
            end
        end
    endtask

    vec_t        vecs[21];
    logic [6:0]  opcs[12];
    logic [31:0] cur;

    initial begin
        exp_t e;
        bit   found;

        vecs[0]  = '{1'b1, 7'h13, 3'd0, 1'b0, 32'h0,        0, 0, '{4, 1, 0, 1'b0, 1'b0, 32'h104, 0, 0}};
        vecs[1]  = '{1'b0, 7'h03, 3'd2, 1'b0, 32'h0,        0, 3, '{8, 1, 1, 1'b0, 1'b0, 32'h108, 4, 0}};
        vecs[2]  = '{1'b0, 7'h23, 3'd2, 1'b0, 32'h0,        0, 2, '{6, 0, 0, 1'b0, 1'b0, 32'h10C, 3, 3}};
        vecs[3]  = '{1'b0, 7'h63, 3'd0, 1'b1, 32'h40,       0, 0, '{3, 0, 0, 1'b0, 1'b0, 32'h40, 0, 0}};
        vecs[4]  = '{1'b0, 7'h63, 3'd1, 1'b0, 32'h80,       0, 0, '{3, 0, 0, 1'b0, 1'b0, 32'h44, 0, 0}};
        vecs[5]  = '{1'b0, 7'h6F, 3'd0, 1'b0, 32'h200,      2, 0, '{6, 1, 2, 1'b0, 1'b0, 32'h200, 0, 0}};
        vecs[6]  = '{1'b0, 7'h0F, 3'd0, 1'b0, 32'h0,        0, 0, '{3, 0, 0, 1'b0, 1'b0, 32'h204, 0, 0}};
        vecs[7]  = '{1'b0, 7'h67, 3'd0, 1'b0, 32'hFFFFFFFC, 0, 0, '{4, 1, 2, 1'b0, 1'b0, 32'hFFFFFFFC, 0, 0}};
        vecs[8]  = '{1'b0, 7'h33, 3'd0, 1'b0, 32'h0,        0, 0, '{4, 1, 0, 1'b0, 1'b0, 32'h0, 0, 0}};
        vecs[9]  = '{1'b0, 7'h37, 3'd0, 1'b0, 32'h0,        0, 0, '{4, 1, 0, 1'b0, 1'b0, 32'h4, 0, 0}};
        vecs[10] = '{1'b0, 7'h17, 3'd0, 1'b0, 32'h0,        0, 0, '{4, 1, 0, 1'b0, 1'b0, 32'h8, 0, 0}};
        vecs[11] = '{1'b0, 7'h63, 3'd0, 1'b1, 32'h42,       0, 0, '{3, 0, 0, 1'b1, 1'b1, 32'h8, 0, 0}};
        vecs[12] = '{1'b1, 7'h00, 3'd0, 1'b0, 32'h0,        0, 0, '{2, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[13] = '{1'b1, 7'h73, 3'd0, 1'b0, 32'h0,        0, 0, '{3, 0, 0, 1'b1, 1'b0, 32'h100, 0, 0}};
        vecs[14] = '{1'b1, 7'h63, 3'd2, 1'b0, 32'h0,        0, 0, '{2, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[15] = '{1'b1, 7'h03, 3'd3, 1'b0, 32'h0,        0, 0, '{2, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[16] = '{1'b1, 7'h23, 3'd3, 1'b0, 32'h0,        0, 0, '{2, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[17] = '{1'b1, 7'h67, 3'd1, 1'b0, 32'h0,        0, 0, '{2, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[18] = '{1'b1, 7'h6F, 3'd0, 1'b0, 32'h202,      0, 0, '{3, 0, 0, 1'b1, 1'b1, 32'h100, 0, 0}};
        vecs[19] = '{1'b1, 7'h03, 3'd4, 1'b0, 32'h0,        0, 0, '{5, 1, 1, 1'b0, 1'b0, 32'h104, 1, 0}};
        vecs[20] = '{1'b0, 7'h63, 3'd0, 1'b0, 32'h42,       0, 0, '{3, 0, 0, 1'b0, 1'b0, 32'h108, 0, 0}};

        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

        rst_n = 1'b0; opcode = 7'h0; funct3 = 3'h0; branch_taken = 1'b0;
        target_addr = 32'h0; mem_ready = 1'b0;

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst) do_reset();
            run_check("vec", i, vecs[i].opc, vecs[i].f3, vecs[i].tk, vecs[i].tgt,
                      vecs[i].fw, vecs[i].mw, vecs[i].e);
        end

        // reset asserted while a store waits in MEM
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            opcode = 7'h23; funct3 = 3'd2;
            mem_ready = !(mem_req && !mem_is_fetch);
            #1;
            if (mem_req && !mem_is_fetch && mem_we) begin found = 1'b1; break; end
        end
        chk("midmem_reached", 0, 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midmem_drop", 0, 32'({mem_req, mem_we, halted}), 32'b000);
        chk("midmem_pc", 0, pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        chk("midmem_refetch", 0, 32'({mem_req, mem_is_fetch}), 32'b11);
        e = model(7'h13, 3'd0, 1'b0, 32'h0, 0, 0, RST_PC);
        run_check("after_midmem", 0, 7'h13, 3'd0, 1'b0, 32'h0, 0, 0, e);

        do_reset();
        cur = RST_PC;
        for (int n = 0; n < 60; n++) begin
            logic [6:0]  ropc;
            logic [2:0]  rf3;
            logic [31:0] rtgt;
            bit          rtk;
            int          rfw;
            int          rmw;
            ropc = opcs[$urandom_range(0, 11)];
            rf3  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
            rtgt = $urandom;
            if ($urandom_range(0, 7) != 0) rtgt[1:0] = 2'b00;
            rtk  = 1'($urandom_range(0, 1));
            rfw  = $urandom_range(0, 2);
            rmw  = $urandom_range(0, 2);
            e = model(ropc, rf3, rtk, rtgt, rfw, rmw, cur);
            run_check("rand", n, ropc, rf3, rtk, rtgt, rfw, rmw, e);
            if (e.halt) begin
                do_reset();
                cur = RST_PC;
            end else begin
                cur = e.pc;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
